// File: rtl/genome_link_pkg.sv
// genome_link_pkg: constants and types shared by the genome link sender and receiver
package genome_link_pkg;
  localparam int BAUD_CLKS = 5208;
  localparam int GENOME_BYTES = 30;
  localparam int GENOME_BITS = 8 * GENOME_BYTES;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: synchronised 8N1 byte receiver, MSB-first, with single-cycle result strobes
module uart_rx_byte
  import genome_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = BAUD_CLKS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       urx,
  output logic       byte_valid,
  output logic       stop_err,
  output logic       start_ok,
  output logic       idle,
  output logic [7:0] byte_data
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic s1_q, s2_q, prev_q, wait_q, wait_d;
  rx_state_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic half, full;
  assign half = cnt_q == CW'(CLKS_PER_BIT/2 - 1);
  assign full = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign idle = st_q == IDLE;
  assign byte_data = sh_q;
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d = sh_q;
    wait_d = wait_q;
    byte_valid = 1'b0;
    stop_err = 1'b0;
    start_ok = 1'b0;
    case (st_q)
      IDLE: begin
        cnt_d = '0;
        if (prev_q && !s2_q) st_d = START;
      end
      START: if (half) begin
        cnt_d = '0;
        bit_d = '0;
        start_ok = !s2_q;
        st_d = s2_q ? IDLE : DATA;
      end
      DATA: if (full) begin
        cnt_d = '0;
        sh_d = {sh_q[6:0], s2_q};
        bit_d = bit_q + 1'b1;
        if (&bit_q) st_d = STOP;
      end
      STOP: if (wait_q) begin
        // after a bad stop bit, hold here until the line is released
        cnt_d = '0;
        if (s2_q) begin
          wait_d = 1'b0;
          st_d = IDLE;
        end
      end else if (full) begin
        cnt_d = '0;
        byte_valid = s2_q;
        stop_err = !s2_q;
        wait_d = !s2_q;
        st_d = s2_q ? IDLE : STOP;
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      prev_q <= 1'b1;
      wait_q <= 1'b0;
      st_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
    end else begin
      s1_q <= urx;
      s2_q <= s1_q;
      prev_q <= s2_q;
      wait_q <= wait_d;
      st_q <= st_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
    end
  end
endmodule

// File: rtl/genome_receiver.sv
// genome_receiver: assembles NUM_BYTES serial bytes into one genome word with abort on error or timeout
module genome_receiver
  import genome_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = BAUD_CLKS,
  parameter int NUM_BYTES = GENOME_BYTES,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   urx,
  output logic [8*NUM_BYTES-1:0] out,
  output logic                   done,
  output logic                   frame_err,
  output logic                   busy
);
  localparam int DW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_BITS + 1);
  logic byte_valid, stop_err, start_ok, idle;
  logic [7:0] byte_data;
  logic [4:0] idx_q, idx_d;
  logic [8*NUM_BYTES-1:0] buf_q, buf_d, out_q, out_d;
  logic [DW-1:0] tdiv_q, tdiv_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic done_q, ferr_q, busy_q, busy_d;
  logic last, waiting, period, tmo, abort;
  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk), .rst_n(rst_n), .urx(urx),
    .byte_valid(byte_valid), .stop_err(stop_err), .start_ok(start_ok),
    .idle(idle), .byte_data(byte_data)
  );
  assign last = byte_valid && idx_q == 5'(NUM_BYTES - 1);
  assign waiting = idle && |idx_q;
  assign period = tdiv_q == DW'(CLKS_PER_BIT - 1);
  assign tmo = waiting && period && tcnt_q == TW'(TIMEOUT_BITS - 1);
  assign abort = last || stop_err || tmo;
  always_comb begin
    buf_d = buf_q;
    if (byte_valid) buf_d[8*idx_q +: 8] = byte_data;
    if (stop_err) buf_d = '0;
  end
  // idle bit periods are only counted between bytes of a genome in progress
  assign tdiv_d = waiting ? (period ? '0 : tdiv_q + 1'b1) : '0;
  assign tcnt_d = waiting ? (period ? tcnt_q + 1'b1 : tcnt_q) : '0;
  assign idx_d = abort ? '0 : byte_valid ? idx_q + 1'b1 : idx_q;
  assign busy_d = abort ? 1'b0 : start_ok ? 1'b1 : busy_q;
  assign out_d = last ? buf_d : out_q;
  assign out = out_q;
  assign done = done_q;
  assign frame_err = ferr_q;
  assign busy = busy_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      buf_q <= '0;
      out_q <= '0;
      tdiv_q <= '0;
      tcnt_q <= '0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      buf_q <= buf_d;
      out_q <= out_d;
      tdiv_q <= tdiv_d;
      tcnt_q <= tcnt_d;
      done_q <= last;
      ferr_q <= stop_err || tmo;
      busy_q <= busy_d;
    end
  end
endmodule

// File: tb/tb_genome_receiver.sv
// tb_genome_receiver: scenario tasks driving serial frames; expected genomes queued and checked on done
module tb_genome_receiver;
  localparam int CPB = 16;
  localparam int NB = 30;
  localparam int GB = 8 * NB;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic urx = 1'b1;
  logic [GB-1:0] out;
  logic done, frame_err, busy;
  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  logic [GB-1:0] exp_q[$];
  logic [GB-1:0] model_out = '0;

  genome_receiver #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB), .TIMEOUT_BITS(20)) dut (
    .clk(clk), .rst_n(rst_n), .urx(urx),
    .out(out), .done(done), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (frame_err) ferr_cnt++;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    urx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      urx = b[i];
      repeat (CPB) @(negedge clk);
    end
    urx = stop;
    repeat (CPB) @(negedge clk);
    urx = 1'b1;
  endtask

  task automatic send_genome(input logic [GB-1:0] g);
    exp_q.push_back(g);
    for (int k = 0; k < NB; k++) send_frame(g[8*k +: 8], 1'b1);
  endtask

  task automatic wait_done(input int d0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    urx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (out !== '0) begin fails++; $display("FAIL reset_out got %h want 0", out); end
    tests++;
    if ({done, frame_err, busy} !== 3'b000) begin
      fails++; $display("FAIL reset_flags got %b want 000", {done, frame_err, busy});
    end
    repeat (200) @(negedge clk);
    tests++;
    if (done_cnt !== 0 || busy !== 1'b0 || out !== '0) begin
      fails++; $display("FAIL reset_idle got done_cnt=%0d busy=%b want 0 0", done_cnt, busy);
    end
  endtask

  task automatic test_full_genome;
    logic [GB-1:0] g, e;
    int d0, f0;
    bit ok;
    for (int k = 0; k < NB; k++) g[8*k +: 8] = 8'(k);
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_genome(g);
    wait_done(d0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL full_done_timeout got no done want done"); end
    e = exp_q.pop_front();
    model_out = e;
    tests++;
    if (out !== e) begin fails++; $display("FAIL full_out got %h want %h", out, e); end
    tests++;
    if (out[7:0] !== 8'h00 || out[239:232] !== 8'h1D) begin
      fails++; $display("FAIL full_ends got %h/%h want 00/1d", out[7:0], out[239:232]);
    end
    tests++;
    if (done_cnt - d0 !== 1) begin fails++; $display("FAIL full_done_count got %0d want 1", done_cnt - d0); end
    tests++;
    if (ferr_cnt - f0 !== 0) begin fails++; $display("FAIL full_no_err got %0d want 0", ferr_cnt - f0); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL full_busy_drop got %b want 0", busy); end
  endtask

  task automatic test_glitch;
    int d0, f0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    urx = 1'b0;
    repeat (4) @(negedge clk);
    urx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    tests++;
    if (done_cnt !== d0 || ferr_cnt !== f0) begin
      fails++; $display("FAIL glitch_pulses got done+%0d err+%0d want 0 0", done_cnt - d0, ferr_cnt - f0);
    end
    tests++;
    if (dut.idx_q !== 5'd0 || busy !== 1'b0) begin
      fails++; $display("FAIL glitch_index got idx=%0d busy=%b want 0 0", dut.idx_q, busy);
    end
  endtask

  task automatic test_frame_error;
    logic [GB-1:0] g, e;
    int d0, f0;
    bit ok;
    f0 = ferr_cnt;
    for (int k = 0; k < 5; k++) send_frame(8'h50 + 8'(k), 1'b1);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL ferr_busy_partial got %b want 1", busy); end
    send_frame(8'h66, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    tests++;
    if (ferr_cnt - f0 !== 1) begin fails++; $display("FAIL ferr_pulse got %0d want 1", ferr_cnt - f0); end
    tests++;
    if (out !== model_out || busy !== 1'b0) begin
      fails++; $display("FAIL ferr_out_kept got busy=%b out=%h want busy=0 out=%h", busy, out, model_out);
    end
    g = {NB{8'hA5}};
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_genome(g);
    wait_done(d0, ok);
    e = exp_q.pop_front();
    model_out = e;
    tests++;
    if (!ok || out !== e) begin fails++; $display("FAIL ferr_recover got %h want %h", out, e); end
    tests++;
    if (done_cnt - d0 !== 1 || ferr_cnt !== f0) begin
      fails++; $display("FAIL ferr_recover_pulses got done+%0d err+%0d want 1 0", done_cnt - d0, ferr_cnt - f0);
    end
  endtask

  task automatic test_timeout;
    int d0, f0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    for (int k = 0; k < 10; k++) send_frame(8'hC0 + 8'(k), 1'b1);
    tests++;
    if (busy !== 1'b1 || ferr_cnt !== f0) begin
      fails++; $display("FAIL tmo_before got busy=%b err+%0d want 1 0", busy, ferr_cnt - f0);
    end
    repeat (21 * CPB) @(negedge clk);
    tests++;
    if (ferr_cnt - f0 !== 1) begin fails++; $display("FAIL tmo_pulse got %0d want 1", ferr_cnt - f0); end
    tests++;
    if (busy !== 1'b0 || out !== model_out || done_cnt !== d0) begin
      fails++; $display("FAIL tmo_abort got busy=%b out=%h want busy=0 out=%h", busy, out, model_out);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [GB-1:0] g, e;
    logic [7:0] b;
    int d0;
    bit ok;
    for (int k = 0; k < 12; k++) send_frame(8'h11 * 8'(k), 1'b1);
    b = 8'hB6;
    urx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 7; i >= 4; i--) begin
      urx = b[i];
      repeat (CPB) @(negedge clk);
    end
    urx = b[3];
    repeat (CPB / 2) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || out !== '0) begin
      fails++; $display("FAIL rstmid_async got busy=%b out=%h want 0 0", busy, out);
    end
    model_out = '0;
    urx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || dut.idx_q !== 5'd0) begin
      fails++; $display("FAIL rstmid_after got busy=%b idx=%0d want 0 0", busy, dut.idx_q);
    end
    g = {NB{8'h3C}};
    d0 = done_cnt;
    send_genome(g);
    wait_done(d0, ok);
    e = exp_q.pop_front();
    model_out = e;
    tests++;
    if (!ok || out !== e || done_cnt - d0 !== 1) begin
      fails++; $display("FAIL rstmid_genome got %h done+%0d want %h done+1", out, done_cnt - d0, e);
    end
  endtask

  initial begin
    test_reset;
    test_full_genome;
    test_glitch;
    test_frame_error;
    test_timeout;
    test_reset_mid_frame;
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/genome_receiver.md
# genome_receiver

Serial receiver for the genome link. Deserialises 10-bit frames (start 0, 8 data bits, stop 1) from `urx`, collects 30 bytes into a 240-bit genome word, and pulses `done` when the full genome is valid. It sits on the FPGA side opposite `SenderModule`, so genomes can be loaded back into the design at 9600 baud from a 50 MHz clock.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per bit period (50 MHz / 9600 baud).
- `NUM_BYTES`, default 30: bytes per genome.
- `TIMEOUT_BITS`, default 20: idle bit periods allowed between bytes of one genome before it is aborted.
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `urx`  in  1  serial line; idles high; asynchronous to `clk`.
- `out`  out  240 (`8*NUM_BYTES`)  last complete genome; byte k at `out[8k+7:8k]`.
- `done`  out  1  one-cycle pulse; `out` is updated in the same cycle.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit or an inter-byte timeout.
- `busy`  out  1  high from the first start bit of a genome until `done` or abort.

## Operation
- `urx` passes through a 2-flop synchroniser. Both flops reset to 1.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a synchronised 1→0 edge, clear the bit-timer and go to START.
  - START: wait `CLKS_PER_BIT/2` cycles, then sample.
    - Sample 1: false start, return to IDLE. No error, byte index unchanged.
    - Sample 0: go to DATA.
  - DATA: sample every `CLKS_PER_BIT` cycles, 8 samples. The first data bit is byte bit 7 (MSB-first). Shift it into an 8-bit shift register.
  - STOP: sample after `CLKS_PER_BIT` cycles.
    - Sample 1: byte accepted. Write it to the assembly buffer at the current byte index, increment the index, go to IDLE.
    - Sample 0: pulse `frame_err`, reset the index to 0, discard the assembly buffer, go to IDLE only after `urx` returns high.
- Byte 0 is the first byte received.
- When byte `NUM_BYTES-1` is accepted:
  - Copy the full assembly buffer to `out`.
  - Pulse `done`.
  - Reset the index to 0 and drop `busy`.
- Inter-byte timeout: while the byte index is nonzero and the FSM is in IDLE, count idle bit periods. On reaching `TIMEOUT_BITS`:
  - Pulse `frame_err`.
  - Reset the index to 0 and drop `busy`.
  - Leave `out` unchanged.
- `out` changes only on `done`. A partial or aborted genome never reaches `out`.

## Timing
- Reset values:
  - `out` = 0; `done` = 0; `frame_err` = 0; `busy` = 0.
  - FSM in IDLE; byte index = 0; timers = 0.
- Falling-edge detect trails the pin by 2 cycles (synchroniser) plus 1 cycle (edge register).
- Data bit n (n = 0..7) is sampled `CLKS_PER_BIT/2 + (n+1)*CLKS_PER_BIT` cycles after the edge is detected.
- The stop bit is sampled `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` cycles after the edge is detected.
- `done` and `frame_err` are registered. Each asserts the cycle after the stop sample, for exactly 1 cycle.
- `busy` rises the cycle after the first valid start sample of a genome.
- Timer widths are `$clog2(CLKS_PER_BIT)` and `$clog2(TIMEOUT_BITS+1)`. The byte index is 5 bits and wraps to 0 only through the accept, error or timeout paths.
- Back-to-back frames are accepted: a start edge in the cycle right after the stop sample is captured.
- Asynchronous reset mid-frame clears all state immediately. The next genome must begin with byte 0.

## Structure
- Shared package `genome_link_pkg` holds:
  - `BAUD_CLKS = 5208`, `GENOME_BYTES = 30`, `GENOME_BITS = 240`.
  - The enum `rx_state_t` {IDLE, START, DATA, STOP}.
  - `SenderModule` is to take its constants from the same package.
- Sub-module `uart_rx_byte` contains the synchroniser, bit FSM and shift register. It outputs `byte_valid`, `byte_data[7:0]` and `stop_err`.
- `genome_receiver` contains the byte index, assembly buffer, timeout counter and output register.

## Test plan
All tests use `CLKS_PER_BIT=16`, `NUM_BYTES=30`, `TIMEOUT_BITS=20`.
- Reset: hold `rst_n`=0 with `urx`=1, then release. `out`=0, `done`=0 and `busy`=0 indefinitely.
- Full genome: send bytes 0x00..0x1D, MSB-first, back-to-back.
  - Exactly one `done` pulse.
  - `out[7:0]`=0x00, `out[239:232]`=0x1D.
  - `frame_err` never asserted.
- Glitch: drive a 4-cycle low pulse on `urx`. No byte is accepted, index stays 0, `frame_err`=0.
- Framing error: send 5 good bytes, then one byte with stop=0.
  - `frame_err` pulses once and `out` is unchanged.
  - A following complete 30-byte genome (0xA5 repeated) yields `done`, with every `out` byte = 0xA5.
- Timeout: send 10 bytes, then idle for 21×16 cycles. `frame_err` pulses once, `busy` drops, `out` is unchanged.
- Reset mid-frame: assert `rst_n`=0 during data bit 4 of byte 12.
  - After release, `busy`=0.
  - A fresh 30-byte genome (0x3C repeated) is received correctly, with every `out` byte = 0x3C.
